// File: rtl/mmio_pkg.sv
// Shared constants, FSM/decode enums and address helpers for the MMIO hub.
package mmio_pkg;

  localparam logic [9:0] OUT_BASE = 10'h000;
  localparam logic [9:0] IN_BASE  = 10'h100;
  localparam logic [9:0] STAT_OFF = 10'h200;

  typedef enum logic {IDLE, RESP} state_e;

  typedef enum logic [1:0] {D_OUT, D_IN, D_STAT, D_ERR} dec_e;

  // Word index of a bank register inside its 256-byte page.
  function automatic logic [5:0] bank_of(input logic [9:0] off);
    return off[7:2];
  endfunction

  function automatic logic [1:0] page_of(input logic [9:0] off);
    return off[9:8];
  endfunction

endpackage

// File: rtl/mmio_if.sv
// Core-side load/store channel: valid/ready request, fixed one-cycle response.
interface mmio_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mmio_debounce.sv
// One input bank: 2-flop synchroniser, whole-bank debouncer and a change pulse
// that fires on the same cycle the stable value is updated.
module mmio_debounce #(
  parameter int BANK_W       = 8,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BANK_W-1:0] pins_i,
  output logic [BANK_W-1:0] stable_o,
  output logic              change_o
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [BANK_W-1:0] sync1_q, sync2_q;
  logic [BANK_W-1:0] cand_q, cand_d;
  logic [BANK_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              change;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    change   = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = cand_q;
        cnt_d    = '0;
        change   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pins_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign change_o = change;

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped hub: N_OUT output banks, N_IN debounced input banks and a
// write-1-to-clear change-flag register behind one 1 KiB address window.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter int                BANK_W       = 8,
  parameter int                N_OUT        = 3,
  parameter int                N_IN         = 3,
  parameter logic [ADDR_W-1:0] IO_BASE      = 32'hFFFF_FC00,
  parameter int                DEBOUNCE_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mmio_if.slave                   bus,
  output logic [N_OUT*BANK_W-1:0] out_pins,
  input  logic [N_IN*BANK_W-1:0]  in_pins,
  output logic                    irq
);

  state_e                  state_q, state_d;
  logic                    accept;
  logic [N_OUT*BANK_W-1:0] out_q, out_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [N_IN-1:0]         flag_q, flag_d, flag_clr, chg;
  logic                    irq_q;
  logic [N_IN*BANK_W-1:0]  in_stable;
  dec_e                    dec;
  logic [9:0]              off;
  logic [5:0]              bank;
  logic                    unused_wdata;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    mmio_debounce #(
      .BANK_W      (BANK_W),
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .pins_i  (in_pins[i*BANK_W +: BANK_W]),
      .stable_o(in_stable[i*BANK_W +: BANK_W]),
      .change_o(chg[i])
    );
  end

  // Address decode; input banks are read-only, so a store there decodes as an error.
  always_comb begin
    off  = bus.req_addr[9:0];
    bank = bank_of(off);
    dec  = D_ERR;
    if (bus.req_addr[ADDR_W-1:10] == IO_BASE[ADDR_W-1:10] && bus.req_addr[1:0] == 2'b00) begin
      if (page_of(off) == page_of(OUT_BASE) && int'(bank) < N_OUT) begin
        dec = D_OUT;
      end else if (page_of(off) == page_of(IN_BASE) && int'(bank) < N_IN && !bus.req_write) begin
        dec = D_IN;
      end else if (off == STAT_OFF) begin
        dec = D_STAT;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = rst_n;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d    = out_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    flag_clr = '0;
    if (accept) begin
      rdata_d = '0;
      err_d   = (dec == D_ERR);
      case (dec)
        D_OUT: begin
          for (int i = 0; i < N_OUT; i++) begin
            if (bank == 6'(i)) begin
              if (bus.req_write) out_d[i*BANK_W +: BANK_W] = bus.req_wdata[BANK_W-1:0];
              else               rdata_d[BANK_W-1:0] = out_q[i*BANK_W +: BANK_W];
            end
          end
        end
        D_IN: begin
          for (int i = 0; i < N_IN; i++) begin
            if (bank == 6'(i)) rdata_d[BANK_W-1:0] = in_stable[i*BANK_W +: BANK_W];
          end
        end
        D_STAT: begin
          if (bus.req_write) flag_clr = bus.req_wdata[N_IN-1:0];
          else               rdata_d[N_IN-1:0] = flag_q;
        end
        default: ;
      endcase
    end
    // A debounced change landing on the same edge as a clear keeps its flag.
    flag_d = (flag_q & ~flag_clr) | chg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      flag_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      irq_q   <= |flag_q;
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign out_pins      = out_q;
  assign irq           = irq_q;
  assign unused_wdata  = ^bus.req_wdata;

endmodule

// File: tb/tb_mmio_hub.sv
// Directed bench for mmio_hub: bus decode, output banks, debounce timing,
// glitch rejection, W1C flag priority, throughput and mid-access reset.
module tb_mmio_hub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] out_pins;
  logic [23:0] in_pins;
  logic        irq;
  int          errors = 0;
  int          checks = 0;

  mmio_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mmio_hub #(
    .DATA_W(32), .ADDR_W(32), .BANK_W(8), .N_OUT(3), .N_IN(3),
    .IO_BASE(32'hFFFF_FC00), .DEBOUNCE_CYC(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .out_pins(out_pins),
    .in_pins (in_pins),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Called at a negedge: waits (bounded) for ready, presents one request,
  // and returns at the negedge after the accepting edge with the response.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL ready_timeout: addr %h never accepted within 20 cycles", addr);
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_valid: addr %h got %b expected 1", addr, bus.rsp_valid);
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_pins = '0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    #3;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h expected 0/0/0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    checks++;
    if (out_pins !== 24'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: got out=%h irq=%b expected 0/0", out_pins, irq);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_out_bank();
    logic [31:0] rd;
    logic        er;
    access(1'b1, 32'hFFFF_FC04, 32'h0000_00A5, rd, er);
    checks++;
    if (out_pins !== 24'h00A500 || er !== 1'b0) begin
      errors++;
      $display("FAIL out_write: got out=%h err=%b expected 00a500/0", out_pins, er);
    end
    access(1'b0, 32'hFFFF_FC04, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0000_00A5 || er !== 1'b0) begin
      errors++;
      $display("FAIL out_read: got rdata=%h err=%b expected 000000a5/0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [4];
    logic [31:0] rd;
    logic        er;
    addrs[0] = 32'hFFFF_FD00;
    addrs[1] = 32'hFFFF_FC02;
    addrs[2] = 32'hFFFF_FC0C;
    addrs[3] = 32'h0000_0004;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, addrs[i], 32'hFFFF_FFFF, rd, er);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || out_pins !== 24'h00A500) begin
        errors++;
        $display("FAIL err_access[%0d]: addr %h got err=%b rdata=%h out=%h expected 1/0/00a500",
                 i, addrs[i], er, rd, out_pins);
      end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    logic        er;
    int          irq_bad = 0;
    in_pins[8] = 1'b1;
    repeat (10) @(negedge clk);
    in_pins[8] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) irq_bad++;
    end
    checks++;
    if (irq_bad != 0) begin errors++; $display("FAIL glitch_irq: irq high on %0d cycles expected 0", irq_bad); end
    access(1'b0, 32'hFFFF_FD04, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL glitch_bank1: got rdata=%h err=%b expected 0/0", rd, er);
    end
    access(1'b0, 32'hFFFF_FE00, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL glitch_status: got %h expected 0", rd); end
  endtask

  task automatic test_debounce();
    logic [31:0] rd;
    logic        er;
    in_pins[7:0] = 8'h3C;
    repeat (17) @(negedge clk);
    access(1'b0, 32'hFFFF_FD00, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL deb_edge18: got rdata=%h irq=%b expected 0/0", rd, irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL deb_irq_edge19: got %b expected 0", irq); end
    access(1'b0, 32'hFFFF_FD00, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0000_003C || irq !== 1'b1) begin
      errors++;
      $display("FAIL deb_edge20: got rdata=%h irq=%b expected 0000003c/1", rd, irq);
    end
    access(1'b0, 32'hFFFF_FE00, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h1 || er !== 1'b0) begin
      errors++;
      $display("FAIL deb_status: got %h err=%b expected 1/0", rd, er);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd;
    logic        er;
    access(1'b1, 32'hFFFF_FE00, 32'h1, rd, er);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL clr_irq_lag: got %b expected 1", irq); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL clr_irq: got %b expected 0", irq); end
    access(1'b0, 32'hFFFF_FE00, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL clr_status: got %h expected 0", rd); end
    in_pins[7:0] = 8'h00;
    repeat (18) @(negedge clk);
    access(1'b1, 32'hFFFF_FE00, 32'h1, rd, er);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL setwin_irq: got %b expected 1", irq); end
    access(1'b0, 32'hFFFF_FE00, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL setwin_status: got %h expected 1", rd); end
    access(1'b1, 32'hFFFF_FE00, 32'h1, rd, er);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL late_clr_irq: got %b expected 0", irq); end
    access(1'b0, 32'hFFFF_FE00, 32'h0, rd, er);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL late_clr_status: got %h expected 0", rd); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int pulses = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'hFFFF_FC04;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clk);
      if (bus.req_ready !== ((k % 2) == 0) || bus.rsp_valid !== ((k % 2) == 1)) bad++;
      if (bus.rsp_valid === 1'b1) begin
        pulses++;
        if (bus.rsp_rdata !== 32'h0000_00A5) bad++;
      end
    end
    bus.req_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL b2b_pattern: %0d bad cycles expected 0", bad); end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulses); end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    access(1'b1, 32'hFFFF_FC00, 32'h0000_005A, rd, er);
    checks++;
    if (out_pins !== 24'h00A55A) begin errors++; $display("FAIL pre_rst_out: got %h expected 00a55a", out_pins); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || out_pins !== 24'h0 || bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got valid=%b out=%h ready=%b expected 0/0/0", bus.rsp_valid, out_pins, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || out_pins !== 24'h0) begin
      errors++;
      $display("FAIL post_rst: got valid=%b ready=%b out=%h expected 0/1/0", bus.rsp_valid, bus.req_ready, out_pins);
    end
  endtask

  initial begin
    test_reset();
    test_out_bank();
    test_errors();
    test_glitch();
    test_debounce();
    test_set_wins();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
